// File: rtl/z16_mem_arbiter.sv
// Round-robin arbiter sharing the Z16 single-port data memory between CPU (port 0) and loader (port 1).
// Define Z16_MEM_ARB_LOCK_EN to enable burst locking via i_lock0/i_lock1.
module z16_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_wen0,
  input  logic              i_wen1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock0,
  input  logic              i_lock1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [1:0] req, wen, gnt;
  logic [1:0] r_rvalid;
  logic       r_prio;
  logic       arb_open;

  assign req = {i_req1, i_req0};
  assign wen = {i_wen1, i_wen0};

`ifdef Z16_MEM_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t     r_state;
  logic       r_owner;
  logic [1:0] lock;

  assign lock = {i_lock1, i_lock0};
  // A locked owner that drops req releases the memory in that same cycle.
  assign arb_open = (r_state == IDLE) || !req[r_owner];
`else
  logic lock_unused;
  assign lock_unused = i_lock0 ^ i_lock1;
  assign arb_open    = 1'b1;
`endif

  always_comb begin
    gnt = '0;
    if (arb_open) begin
      if (&req) gnt[r_prio] = 1'b1;
      else      gnt = req;
    end
`ifdef Z16_MEM_ARB_LOCK_EN
    else begin
      gnt[r_owner] = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio   <= 1'b0;
      r_rvalid <= '0;
`ifdef Z16_MEM_ARB_LOCK_EN
      r_state  <= IDLE;
      r_owner  <= 1'b0;
`endif
    end else begin
      r_rvalid <= gnt & ~wen;
      if (arb_open) begin
        // Pointer moves to whichever port was not just served.
        if (|gnt) r_prio <= gnt[0];
`ifdef Z16_MEM_ARB_LOCK_EN
        r_state <= (|(gnt & lock)) ? LOCKED : IDLE;
        if (|gnt) r_owner <= gnt[1];
      end else if (!lock[r_owner]) begin
        r_state <= IDLE;
        r_prio  <= ~r_owner;
`endif
      end
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    if (gnt[0]) begin
      o_mem_addr  = i_addr0;
      o_mem_wen   = i_wen0;
      o_mem_wdata = i_wdata0;
    end else if (gnt[1]) begin
      o_mem_addr  = i_addr1;
      o_mem_wen   = i_wen1;
      o_mem_wdata = i_wdata1;
    end
  end

  assign o_gnt0    = gnt[0];
  assign o_gnt1    = gnt[1];
  assign o_rvalid0 = r_rvalid[0];
  assign o_rvalid1 = r_rvalid[1];
  assign o_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Scoreboard bench for z16_mem_arbiter: directed stimulus pushes expected grants/reads, a negedge monitor checks them.
module tb_z16_mem_arbiter;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_req0 = 0, i_req1 = 0, i_wen0 = 0, i_wen1 = 0, i_lock0 = 0, i_lock1 = 0;
  logic [15:0] i_addr0 = 0, i_addr1 = 0, i_wdata0 = 0, i_wdata1 = 0;
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_mem_wen;
  logic [15:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [15:0] i_mem_rdata = 0;

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .i_lock0(i_lock0), .i_lock1(i_lock1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata(o_rdata), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int cyc; int port; logic wen; logic [15:0] addr; logic [15:0] wdata; } gexp_t;
  typedef struct { int cyc; int port; logic [15:0] data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] mem [0:255];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cyc %0d): got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Synchronous-read memory; port values are captured mid-cycle so edge ordering cannot race.
  initial begin
    logic [7:0]  a;
    logic        w;
    logic [15:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'hA5A5;
    forever begin
      @(negedge i_clk);
      a = o_mem_addr[7:0]; w = o_mem_wen; d = o_mem_wdata;
      @(posedge i_clk);
      i_mem_rdata = mem[a];
      if (w) mem[a] = d;
    end
  end

  gexp_t g;
  rexp_t r;
  always @(negedge i_clk) begin
    chk("gnt_excl", {31'd0, o_gnt0 & o_gnt1}, 0);
    if (o_gnt0 || o_gnt1) begin
      if (gq.size() == 0) chk("gnt_unexpected", {31'd0, o_gnt1}, 32'hFFFF_FFFF);
      else begin
        g = gq.pop_front();
        chk("gnt_cyc", cyc, g.cyc);
        chk("gnt_port", {31'd0, o_gnt1}, g.port);
        chk("mem_wen", {31'd0, o_mem_wen}, {31'd0, g.wen});
        chk("mem_addr", {16'd0, o_mem_addr}, {16'd0, g.addr});
        chk("mem_wdata", {16'd0, o_mem_wdata}, {16'd0, g.wdata});
      end
    end else begin
      chk("idle_wen", {31'd0, o_mem_wen}, 0);
      chk("idle_addr", {16'd0, o_mem_addr}, 0);
      chk("idle_wdata", {16'd0, o_mem_wdata}, 0);
    end
    if (o_rvalid0 || o_rvalid1) begin
      chk("rvalid_excl", {31'd0, o_rvalid0 & o_rvalid1}, 0);
      if (rq.size() == 0) chk("rvalid_unexpected", {31'd0, o_rvalid1}, 32'hFFFF_FFFF);
      else begin
        r = rq.pop_front();
        chk("rvalid_cyc", cyc, r.cyc);
        chk("rvalid_port", {31'd0, o_rvalid1}, r.port);
        chk("rdata", {16'd0, o_rdata}, {16'd0, r.data});
      end
    end
  end

  task automatic set0(input logic rq_, input logic w, input logic [15:0] a, input logic [15:0] d, input logic l);
    i_req0 = rq_; i_wen0 = w; i_addr0 = a; i_wdata0 = d; i_lock0 = l;
  endtask
  task automatic set1(input logic rq_, input logic w, input logic [15:0] a, input logic [15:0] d, input logic l);
    i_req1 = rq_; i_wen1 = w; i_addr1 = a; i_wdata1 = d; i_lock1 = l;
  endtask
  task automatic tick();
    @(posedge i_clk); #1;
  endtask
  task automatic eg(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    gexp_t e;
    e.cyc = cyc; e.port = p; e.wen = w; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask
  task automatic er(input int p, input logic [15:0] d);
    rexp_t e;
    e.cyc = cyc + 1; e.port = p; e.data = d;
    rq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa, wd;
    #3;
    chk("rst_rvalid0", {31'd0, o_rvalid0}, 0);
    chk("rst_rvalid1", {31'd0, o_rvalid1}, 0);
    chk("rst_gnt", {30'd0, o_gnt1, o_gnt0}, 0);
    chk("rst_mem_wen", {31'd0, o_mem_wen}, 0);
    chk("rst_mem_addr", {16'd0, o_mem_addr}, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Single read: grant same cycle, data one cycle later.
    set0(1, 0, 16'h0010, 0, 0); eg(0, 0, 16'h0010, 0); er(0, 16'hBEEF); tick();
    set0(0, 0, 0, 0, 0); tick();

    // Contested stream, pointer now favours port 1.
    set0(1, 0, 16'h0020, 0, 0); set1(1, 1, 16'h0030, 16'h1234, 0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) eg(1, 1, 16'h0030, 16'h1234);
      else begin eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); end
      tick();
    end

    // Port 1 alone three times, then conflict goes to port 0.
    set0(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      wd = 16'h1111 * 16'(k + 1);
      set1(1, 1, 16'h0030, wd, 0); eg(1, 1, 16'h0030, wd); tick();
    end
    set0(1, 0, 16'h0020, 0, 0); set1(1, 1, 16'h0030, 16'h4444, 0);
    eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); tick();
    set0(0, 0, 0, 0, 0); eg(1, 1, 16'h0030, 16'h4444); tick();
    set1(0, 0, 0, 0, 0); tick();

    // Burst of four port-1 writes with lock on the first three.
    set0(1, 0, 16'h0020, 0, 0); eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); tick();
    for (int k = 0; k < 4; k++) begin
      wa = 16'h0040 + 16'(2 * k);
      wd = 16'hD000 + 16'(k);
      set1(1, 1, wa, wd, k < 3);
`ifndef Z16_MEM_ARB_LOCK_EN
      if (k > 0) begin eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); tick(); end
`endif
      eg(1, 1, wa, wd); tick();
    end
    set1(0, 0, 0, 0, 0); eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); tick();
    set0(0, 0, 0, 0, 0); tick();

    // Reset pulse drops an in-flight read and restores port-0 priority.
    set1(1, 1, 16'h0030, 16'h4444, 0); eg(1, 1, 16'h0030, 16'h4444); tick();
    set1(0, 0, 0, 0, 0); set0(1, 0, 16'h0010, 0, 0); eg(0, 0, 16'h0010, 0); tick();
    set0(0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    #1 chk("rst_pulse_rvalid0", {31'd0, o_rvalid0}, 0);
    #1 i_rst_n = 1'b1;
    tick();

    // Contested after reset to port 0; port 1 then abandons its write.
    set0(1, 0, 16'h0020, 0, 0); set1(1, 1, 16'h0030, 16'h5555, 0);
    eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); tick();
    set1(0, 0, 0, 0, 0); eg(0, 0, 16'h0020, 0); er(0, 16'hA5A5); tick();
    set0(0, 0, 0, 0, 0); tick(); tick();

    chk("mem_0030", {16'd0, mem[8'h30]}, 32'h4444);
    chk("mem_0046", {16'd0, mem[8'h46]}, 32'hD003);
    chk("gnt_queue_empty", gq.size(), 0);
    chk("rd_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
